// File: rtl/ifu_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch unit: reset PC, NOP encoding,
// fetch-entry layout and address-range helpers.
package ifu_fetch_queue_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int          DEFAULT_IM_WORDS = 4096;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // Instructions are 32-bit words; PCs advance and align on this granule.
  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue_fetch_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from storage so
// the consumer side has no combinational path from the write data.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, detects address faults and
// buffers {pc, instr, exc} entries toward decode through fetch_fifo.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                IM_WORDS = DEFAULT_IM_WORDS,
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              out_exc
);

  localparam int ENTRY_W = ADDR_W + DATA_W + 1;
  localparam int CNT_W   = $clog2(DEPTH+1);

  // One extra bit keeps RESET_PC + 4*IM_WORDS from overflowing.
  localparam logic [ADDR_W:0] LO_BOUND = {1'b0, RESET_PC};
  localparam logic [ADDR_W:0] HI_BOUND = LO_BOUND + ((ADDR_W+1)'(IM_WORDS) << WORD_SHIFT);

  logic [ADDR_W-1:0]  fetch_pc;
  logic               halted;
  logic               fault;
  logic               pop;
  logic               push;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = !redirect_valid && !halted && ((count != CNT_W'(DEPTH)) || pop);

  assign fault = (fetch_pc[WORD_SHIFT-1:0] != '0)
               || ({1'b0, fetch_pc} < LO_BOUND)
               || ({1'b0, fetch_pc} >= HI_BOUND);

  assign entry = fault ? {fetch_pc, DATA_W'(NOP_INSTR), 1'b1}
                       : {fetch_pc, imem_rdata, 1'b0};

  // A faulting entry parks the PC on the bad address until a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      halted   <= 1'b0;
    end else if (push) begin
      if (fault) halted   <= 1'b1;
      else       fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign out_pc    = head[ENTRY_W-1 -: ADDR_W];
  assign out_instr = head[DATA_W:1];
  assign out_exc   = head[0];

endmodule
